// File: rtl/ddr_rd_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module   : ddr_rd_arbiter_if
//  Brief    : Requester and DDR read-engine signal bundle for ddr_rd_arbiter.
//  Revision : 1.0 - initial release
// ============================================================================
interface ddr_rd_arbiter_if #(
  parameter int ADDR_WIDTH    = 30,
  parameter int DATA_NUM_BITS = 16
);
  logic                     init_calib_complete_i;
  logic [1:0]               arb_req_i;
  logic [1:0]               rd_ddr_en_i;
  logic [DATA_NUM_BITS-1:0] rd_burst_num0_i;
  logic [DATA_NUM_BITS-1:0] rd_burst_num1_i;
  logic [ADDR_WIDTH-1:0]    rd_start_addr0_i;
  logic [ADDR_WIDTH-1:0]    rd_start_addr1_i;
  logic                     rd_ddr_done_i;

  logic [1:0]               arb_ack_o;
  logic [1:0]               grant_o;
  logic                     rd_ddr_en_o;
  logic [DATA_NUM_BITS-1:0] rd_burst_num_o;
  logic [ADDR_WIDTH-1:0]    rd_start_addr_o;
  logic [1:0]               rd_done_o;
  logic                     busy_o;
  logic                     timeout_err_o;

  // Arbiter side
  modport slave (
    input  init_calib_complete_i, arb_req_i, rd_ddr_en_i,
           rd_burst_num0_i, rd_burst_num1_i,
           rd_start_addr0_i, rd_start_addr1_i, rd_ddr_done_i,
    output arb_ack_o, grant_o, rd_ddr_en_o, rd_burst_num_o,
           rd_start_addr_o, rd_done_o, busy_o, timeout_err_o
  );

  // Requester / DDR engine side
  modport master (
    output init_calib_complete_i, arb_req_i, rd_ddr_en_i,
           rd_burst_num0_i, rd_burst_num1_i,
           rd_start_addr0_i, rd_start_addr1_i, rd_ddr_done_i,
    input  arb_ack_o, grant_o, rd_ddr_en_o, rd_burst_num_o,
           rd_start_addr_o, rd_done_o, busy_o, timeout_err_o
  );
endinterface
`default_nettype wire

// File: rtl/ddr_rd_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : ddr_rd_arbiter
//  Brief    : Two-requester round-robin arbiter for a DDR read port with watchdog.
//  Revision : 1.0 - initial release
// ============================================================================
module ddr_rd_arbiter #(
  parameter int ADDR_WIDTH    = 30,
  parameter int DATA_NUM_BITS = 16,
  parameter int TO_LIMIT      = 65535
) (
  input wire              clk_i,
  input wire              rstn_i,
  ddr_rd_arbiter_if.slave arb
);

  localparam logic [2:0] c_ST_CALIB = 3'd0;
  localparam logic [2:0] c_ST_IDLE  = 3'd1;
  localparam logic [2:0] c_ST_ACK   = 3'd2;
  localparam logic [2:0] c_ST_BUSY  = 3'd3;
  localparam logic [2:0] c_ST_REL   = 3'd4;

  localparam int                 c_CNT_W   = $clog2(TO_LIMIT + 1);
  localparam logic [c_CNT_W-1:0] c_TO_LAST = c_CNT_W'(TO_LIMIT - 1);

  logic [2:0]         state_q, state_d;
  logic               owner_q, owner_d;
  logic               last_q,  last_d;
  logic [c_CNT_W-1:0] wd_q,    wd_d;
  logic               terr_q,  terr_d;

  logic               w_winner;
  logic [1:0]         w_owner_oh;

  // On a tie the requester that was not served last wins
  assign w_winner   = (arb.arb_req_i == 2'b11) ? ~last_q : arb.arb_req_i[1];
  assign w_owner_oh = owner_q ? 2'b10 : 2'b01;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q <= c_ST_CALIB;
      owner_q <= 1'b0;
      last_q  <= 1'b1;
      wd_q    <= '0;
      terr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      wd_q    <= wd_d;
      terr_q  <= terr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    wd_d    = wd_q;
    terr_d  = terr_q;
    case (state_q)
      c_ST_CALIB: begin
        if (arb.init_calib_complete_i) state_d = c_ST_IDLE;
      end
      c_ST_IDLE: begin
        if (|arb.arb_req_i) begin
          state_d = c_ST_ACK;
          owner_d = w_winner;
        end
      end
      c_ST_ACK: begin
        state_d = c_ST_BUSY;
        wd_d    = '0;
      end
      c_ST_BUSY: begin
        wd_d = wd_q + 1'b1;
        // A done arriving in the watchdog's last cycle is a clean completion
        if (arb.rd_ddr_done_i) begin
          state_d = c_ST_REL;
          last_d  = owner_q;
        end else if (wd_q == c_TO_LAST) begin
          state_d = c_ST_REL;
          last_d  = owner_q;
          terr_d  = 1'b1;
        end
      end
      c_ST_REL: begin
        state_d = c_ST_IDLE;
      end
      default: begin
        state_d = c_ST_CALIB;
      end
    endcase
  end

  always_comb begin
    arb.arb_ack_o       = 2'b00;
    arb.grant_o         = 2'b00;
    arb.rd_done_o       = 2'b00;
    arb.rd_ddr_en_o     = 1'b0;
    arb.rd_burst_num_o  = '0;
    arb.rd_start_addr_o = '0;
    case (state_q)
      c_ST_ACK: begin
        arb.arb_ack_o = w_owner_oh;
        arb.grant_o   = w_owner_oh;
      end
      c_ST_BUSY: begin
        arb.grant_o         = w_owner_oh;
        arb.rd_ddr_en_o     = arb.rd_ddr_en_i[owner_q];
        arb.rd_burst_num_o  = owner_q ? arb.rd_burst_num1_i  : arb.rd_burst_num0_i;
        arb.rd_start_addr_o = owner_q ? arb.rd_start_addr1_i : arb.rd_start_addr0_i;
      end
      c_ST_REL: begin
        arb.rd_done_o = w_owner_oh;
      end
      default: begin
        arb.arb_ack_o = 2'b00;
      end
    endcase
  end

  assign arb.busy_o        = (state_q != c_ST_CALIB) && (state_q != c_ST_IDLE);
  assign arb.timeout_err_o = terr_q;

endmodule
`default_nettype wire

// File: tb/tb_ddr_rd_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ddr_rd_arbiter
//  Brief    : Self-checking bench for ddr_rd_arbiter (scoreboard of acks/dones).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_ddr_rd_arbiter;

  localparam int AW = 30;
  localparam int DW = 16;
  localparam int TO = 8;

  logic clk_i  = 1'b0;
  logic rstn_i = 1'b0;
  int   errors = 0;
  int   checks = 0;

  logic [1:0] exp_ack_q[$];
  logic [1:0] exp_done_q[$];
  logic       model_last = 1'b1;

  always #5 clk_i = ~clk_i;

  ddr_rd_arbiter_if #(.ADDR_WIDTH(AW), .DATA_NUM_BITS(DW)) bus ();

  ddr_rd_arbiter #(
    .ADDR_WIDTH   (AW),
    .DATA_NUM_BITS(DW),
    .TO_LIMIT     (TO)
  ) dut (
    .clk_i (clk_i),
    .rstn_i(rstn_i),
    .arb   (bus.slave)
  );

  task automatic step();
    @(negedge clk_i);
  endtask

  function automatic logic [1:0] rr_pick(input logic [1:0] req, input logic last);
    if (req == 2'b11) return last ? 2'b01 : 2'b10;
    return req;
  endfunction

  task automatic test_reset();
    rstn_i                    = 1'b0;
    bus.init_calib_complete_i = 1'b0;
    bus.arb_req_i             = 2'b10;
    bus.rd_ddr_en_i           = 2'b11;
    bus.rd_burst_num0_i       = 16'd3;
    bus.rd_burst_num1_i       = 16'd4;
    bus.rd_start_addr0_i      = 30'h55;
    bus.rd_start_addr1_i      = 30'h66;
    bus.rd_ddr_done_i         = 1'b0;
    repeat (2) step();
    checks++;
    if ({bus.arb_ack_o, bus.grant_o, bus.rd_done_o, bus.rd_ddr_en_o,
         bus.busy_o, bus.timeout_err_o} !== 9'd0) begin
      errors++;
      $display("FAIL reset_ctrl: got ack=%b grant=%b done=%b en=%b busy=%b terr=%b, expected all 0",
               bus.arb_ack_o, bus.grant_o, bus.rd_done_o, bus.rd_ddr_en_o,
               bus.busy_o, bus.timeout_err_o);
    end
    checks++;
    if (bus.rd_burst_num_o !== 16'd0 || bus.rd_start_addr_o !== 30'd0) begin
      errors++;
      $display("FAIL reset_data: got burst=%0d addr=%h, expected 0", bus.rd_burst_num_o, bus.rd_start_addr_o);
    end
  endtask

  task automatic test_calib_wait();
    logic [1:0] e;
    rstn_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      checks++;
      if (bus.arb_ack_o !== 2'b00 || bus.busy_o !== 1'b0) begin
        errors++;
        $display("FAIL calib_hold: got ack=%b busy=%b, expected 00/0", bus.arb_ack_o, bus.busy_o);
      end
    end
    bus.init_calib_complete_i = 1'b1;
    exp_ack_q.push_back(rr_pick(2'b10, model_last));
    step();
    checks++;
    if (bus.arb_ack_o !== 2'b00) begin
      errors++;
      $display("FAIL calib_early_ack: got ack=%b, expected 00", bus.arb_ack_o);
    end
    bus.init_calib_complete_i = 1'b0;
    step();
    e = exp_ack_q.pop_front();
    checks++;
    if (bus.arb_ack_o !== e || bus.grant_o !== e || bus.busy_o !== 1'b1) begin
      errors++;
      $display("FAIL calib_ack: got ack=%b grant=%b busy=%b, expected ack=grant=%b busy=1",
               bus.arb_ack_o, bus.grant_o, bus.busy_o, e);
    end
  endtask

  task automatic test_mux();
    logic [1:0] e;
    bus.rd_start_addr0_i = 30'h2000;
    bus.rd_burst_num0_i  = 16'd7;
    bus.rd_start_addr1_i = 30'h1000;
    bus.rd_burst_num1_i  = 16'd288;
    bus.rd_ddr_en_i      = 2'b01;
    exp_done_q.push_back(2'b10);
    step();
    checks++;
    if (bus.rd_start_addr_o !== 30'h1000 || bus.rd_burst_num_o !== 16'd288) begin
      errors++;
      $display("FAIL mux_data: got addr=%h burst=%0d, expected 1000/288", bus.rd_start_addr_o, bus.rd_burst_num_o);
    end
    checks++;
    if (bus.rd_ddr_en_o !== 1'b0) begin
      errors++;
      $display("FAIL mux_en_other: got en=%b, expected 0", bus.rd_ddr_en_o);
    end
    bus.rd_ddr_en_i = 2'b10;
    bus.arb_req_i   = 2'b00;
    step();
    checks++;
    if (bus.rd_ddr_en_o !== 1'b1) begin
      errors++;
      $display("FAIL mux_en_owner: got en=%b, expected 1", bus.rd_ddr_en_o);
    end
    checks++;
    if (bus.grant_o !== 2'b10) begin
      errors++;
      $display("FAIL grant_hold: got grant=%b, expected 10", bus.grant_o);
    end
    bus.rd_ddr_done_i = 1'b1;
    step();
    bus.rd_ddr_done_i = 1'b0;
    e = exp_done_q.pop_front();
    checks++;
    if (bus.rd_done_o !== e || bus.grant_o !== 2'b00 || bus.rd_ddr_en_o !== 1'b0 ||
        bus.rd_start_addr_o !== 30'd0 || bus.busy_o !== 1'b1) begin
      errors++;
      $display("FAIL done_rel: got done=%b grant=%b en=%b addr=%h busy=%b, expected done=%b grant=00 en=0 addr=0 busy=1",
               bus.rd_done_o, bus.grant_o, bus.rd_ddr_en_o, bus.rd_start_addr_o, bus.busy_o, e);
    end
    model_last = 1'b1;
    step();
    checks++;
    if (bus.busy_o !== 1'b0 || bus.rd_done_o !== 2'b00) begin
      errors++;
      $display("FAIL rel_to_idle: got busy=%b done=%b, expected 0/00", bus.busy_o, bus.rd_done_o);
    end
  endtask

  task automatic test_spurious_done();
    bus.rd_ddr_done_i = 1'b1;
    step();
    bus.rd_ddr_done_i = 1'b0;
    checks++;
    if (bus.rd_done_o !== 2'b00 || bus.busy_o !== 1'b0) begin
      errors++;
      $display("FAIL spurious_done: got done=%b busy=%b, expected 00/0", bus.rd_done_o, bus.busy_o);
    end
    step();
    checks++;
    if (bus.busy_o !== 1'b0 || bus.arb_ack_o !== 2'b00) begin
      errors++;
      $display("FAIL spurious_idle: got busy=%b ack=%b, expected 0/00", bus.busy_o, bus.arb_ack_o);
    end
  endtask

  task automatic test_round_robin();
    logic [1:0] e;
    int         waited;
    bus.arb_req_i = 2'b11;
    for (int g = 0; g < 4; g++) begin
      e = rr_pick(2'b11, model_last);
      exp_ack_q.push_back(e);
      exp_done_q.push_back(e);
      waited = 0;
      do begin
        step();
        waited++;
      end while (bus.arb_ack_o === 2'b00 && waited < 6);
      e = exp_ack_q.pop_front();
      checks++;
      if (bus.arb_ack_o !== e || bus.grant_o !== e) begin
        errors++;
        $display("FAIL rr_ack[%0d]: got ack=%b grant=%b, expected %b", g, bus.arb_ack_o, bus.grant_o, e);
      end
      if (g > 0) begin
        checks++;
        if (waited !== 2) begin
          errors++;
          $display("FAIL rr_turnaround[%0d]: got %0d cycles from release, expected 2", g, waited);
        end
      end
      step();
      step();
      bus.rd_ddr_done_i = 1'b1;
      step();
      bus.rd_ddr_done_i = 1'b0;
      e = exp_done_q.pop_front();
      checks++;
      if (bus.rd_done_o !== e) begin
        errors++;
        $display("FAIL rr_done[%0d]: got done=%b, expected %b", g, bus.rd_done_o, e);
      end
      model_last = (e == 2'b10);
    end
    bus.arb_req_i = 2'b00;
  endtask

  task automatic test_done_at_timeout();
    logic [1:0] e;
    step();
    bus.arb_req_i = 2'b01;
    exp_ack_q.push_back(rr_pick(2'b01, model_last));
    step();
    bus.arb_req_i = 2'b00;
    e = exp_ack_q.pop_front();
    checks++;
    if (bus.arb_ack_o !== e) begin
      errors++;
      $display("FAIL dt_ack: got ack=%b, expected %b", bus.arb_ack_o, e);
    end
    repeat (TO) step();
    bus.rd_ddr_done_i = 1'b1;
    step();
    bus.rd_ddr_done_i = 1'b0;
    checks++;
    if (bus.rd_done_o !== 2'b01 || bus.timeout_err_o !== 1'b0) begin
      errors++;
      $display("FAIL done_at_timeout: got done=%b terr=%b, expected 01/0", bus.rd_done_o, bus.timeout_err_o);
    end
    model_last = 1'b0;
  endtask

  task automatic test_timeout();
    logic [1:0] e;
    int         busy_cycles;
    int         early;
    step();
    bus.arb_req_i = 2'b01;
    exp_ack_q.push_back(rr_pick(2'b01, model_last));
    exp_done_q.push_back(2'b01);
    step();
    bus.arb_req_i = 2'b00;
    e = exp_ack_q.pop_front();
    checks++;
    if (bus.arb_ack_o !== e) begin
      errors++;
      $display("FAIL to_ack: got ack=%b, expected %b", bus.arb_ack_o, e);
    end
    busy_cycles = 0;
    early       = 0;
    do begin
      step();
      if (bus.grant_o !== 2'b00) busy_cycles++;
      if (bus.grant_o !== 2'b00 && bus.timeout_err_o !== 1'b0) early++;
    end while (bus.rd_done_o === 2'b00 && busy_cycles < 20);
    e = exp_done_q.pop_front();
    checks++;
    if (busy_cycles !== TO || early !== 0) begin
      errors++;
      $display("FAIL to_length: got %0d busy cycles (%0d with early flag), expected %0d/0", busy_cycles, early, TO);
    end
    checks++;
    if (bus.rd_done_o !== e || bus.timeout_err_o !== 1'b1) begin
      errors++;
      $display("FAIL to_release: got done=%b terr=%b, expected %b/1", bus.rd_done_o, bus.timeout_err_o, e);
    end
    model_last = 1'b0;
    step();
    bus.arb_req_i = 2'b10;
    exp_ack_q.push_back(rr_pick(2'b10, model_last));
    step();
    bus.arb_req_i = 2'b00;
    e = exp_ack_q.pop_front();
    checks++;
    if (bus.arb_ack_o !== e) begin
      errors++;
      $display("FAIL to_next_ack: got ack=%b, expected %b", bus.arb_ack_o, e);
    end
    step();
    bus.rd_ddr_done_i = 1'b1;
    step();
    bus.rd_ddr_done_i = 1'b0;
    checks++;
    if (bus.rd_done_o !== 2'b10 || bus.timeout_err_o !== 1'b1) begin
      errors++;
      $display("FAIL to_sticky: got done=%b terr=%b, expected 10/1", bus.rd_done_o, bus.timeout_err_o);
    end
    model_last = 1'b1;
  endtask

  task automatic test_reset_mid_busy();
    logic [1:0] e;
    step();
    bus.arb_req_i   = 2'b01;
    bus.rd_ddr_en_i = 2'b01;
    step();
    step();
    checks++;
    if (bus.grant_o !== 2'b01 || bus.rd_ddr_en_o !== 1'b1) begin
      errors++;
      $display("FAIL rst_pre: got grant=%b en=%b, expected 01/1", bus.grant_o, bus.rd_ddr_en_o);
    end
    #2 rstn_i = 1'b0;
    #1;
    checks++;
    if ({bus.arb_ack_o, bus.grant_o, bus.rd_done_o, bus.rd_ddr_en_o, bus.busy_o,
         bus.timeout_err_o} !== 9'd0 || bus.rd_start_addr_o !== 30'd0 ||
        bus.rd_burst_num_o !== 16'd0) begin
      errors++;
      $display("FAIL rst_async: got ack=%b grant=%b done=%b en=%b busy=%b terr=%b, expected all 0",
               bus.arb_ack_o, bus.grant_o, bus.rd_done_o, bus.rd_ddr_en_o, bus.busy_o, bus.timeout_err_o);
    end
    step();
    rstn_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (bus.arb_ack_o !== 2'b00 || bus.busy_o !== 1'b0 || bus.rd_done_o !== 2'b00) begin
        errors++;
        $display("FAIL rst_recalib: got ack=%b busy=%b done=%b, expected 00/0/00",
                 bus.arb_ack_o, bus.busy_o, bus.rd_done_o);
      end
    end
    bus.init_calib_complete_i = 1'b1;
    exp_ack_q.push_back(rr_pick(2'b01, 1'b1));
    step();
    step();
    e = exp_ack_q.pop_front();
    checks++;
    if (bus.arb_ack_o !== e) begin
      errors++;
      $display("FAIL rst_reack: got ack=%b, expected %b", bus.arb_ack_o, e);
    end
    bus.arb_req_i = 2'b00;
  endtask

  initial begin
    test_reset();
    test_calib_wait();
    test_mux();
    test_spurious_done();
    test_round_robin();
    test_done_at_timeout();
    test_timeout();
    test_reset_mid_busy();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
